comple_serial: RTL and testbench
================================

Name: comple_serial

Overview:
- Parametrised, digit-serial successor to the 16-bit combinational complementor.
- Applies one of four sign operations to a WIDTH-bit two's-complement operand: pass, negate, absolute value, or negative absolute value.
- Processes DIGIT bits per clock through a conditional-invert and ripple-increment slice, carrying between cycles.
- Valid/ready handshakes on both sides; sits between an operand producer and an arithmetic datapath consumer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be at least 2.
- DIGIT, 4, bits processed per cycle; WIDTH must be an exact multiple of DIGIT.
- STEPS, WIDTH/DIGIT, derived (localparam); number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand and mode present.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  two's-complement operand.
- in_mode  input  2  00 PASS, 01 NEG, 10 ABS, 11 NABS.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  result not representable (overflow).
- out_zero  output  1  out_data is zero.

Behaviour:
- Reset (async assert, sync release): state IDLE, count 0, all internal registers 0. Outputs: in_ready=1, out_valid=0, out_data=0, out_ovf=0, out_zero=0.
- State machine, one-hot or encoded, states IDLE, RUN, DONE:
  - IDLE: in_ready=1. Transfer occurs when in_valid && in_ready at a rising edge.
  - On transfer: latch operand and mode; compute inv (PASS 0, NEG 1, ABS in_data[MSB], NABS ~in_data[MSB]); set carry=inv, count=0; go to RUN.
  - RUN: in_ready=0. Each cycle, digit[count] (LSB digit first) becomes (digit ^ {DIGIT{inv}}) + carry, written into result digit[count]. carry takes the digit carry-out. count increments.
  - When count==STEPS-1: write the final digit and go to DONE.
  - DONE: out_valid=1; out_data, out_ovf and out_zero are stable. Stay in DONE while out_ready=0. When out_ready=1, go to IDLE.
- Latency: out_valid rises exactly STEPS cycles after the accepting edge (4 cycles at the defaults).
- Throughput: one operation per STEPS+2 cycles minimum. in_ready is combinationally 1 only in IDLE and never depends on out_ready.
- out_ovf = inv && (operand == 1 followed by WIDTH-1 zeros). In that case the result equals the operand (most-negative value). NABS never overflows.
- out_zero is computed from the final result. The final carry-out is discarded.
- in_data/in_mode changes outside a transfer are ignored; latched values are used throughout RUN.
- out_data holds its last value after leaving DONE until the next result. out_valid must be 0 outside DONE.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the partial result is lost and no out_valid pulse occurs.
- STEPS==1 (DIGIT==WIDTH): RUN lasts one cycle; same handshake rules apply.

Decomposition:
- Package comple_pkg:
  - mode_t enum (MODE_PASS, MODE_NEG, MODE_ABS, MODE_NABS).
  - state_t enum (S_IDLE, S_RUN, S_DONE).
  - Function inv_sel(mode, msb).
- Sub-module comple_digit: combinational slice. Inputs DIGIT-bit digit, inv, cin; outputs DIGIT-bit sum and cout. Instantiated once and time-multiplexed by count.
- Top level holds the FSM, counter, operand register, result register and flags.

Test Plan (WIDTH=16, DIGIT=4):
- ABS of 0xFFFB, in_valid pulse, out_ready=1: out_valid is 1 exactly 4 cycles after accept, out_data=0x0005, out_ovf=0, out_zero=0, then IDLE.
- NEG of 0x0000: out_data=0x0000, out_zero=1, out_ovf=0. NEG of 0x0001: out_data=0xFFFF.
- ABS of 0x8000 and NEG of 0x8000: out_data=0x8000, out_ovf=1. NABS of 0x8000: out_data=0x8000, out_ovf=0.
- PASS 0x1234 gives 0x1234. NABS 0x0007 gives 0xFFF9. NABS 0xFFF9 gives 0xFFF9.
- Backpressure: out_ready=0 for 3 cycles in DONE. out_valid and out_data stay stable, in_ready=0 even with in_valid=1, and the second operand is accepted only after out_ready=1 and the return to IDLE.
- rst_n pulsed low during the 2nd RUN cycle: all outputs go to reset values immediately, no out_valid is seen, and a fresh operation afterwards produces a correct result.

Source files
------------

// File: rtl/comple_pkg.sv
// Shared types for the digit-serial sign-operation unit.
// Mode and state encodings plus the invert-select helper.
package comple_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_NABS = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // ABS inverts negatives, NABS inverts non-negatives
  function automatic logic inv_sel(mode_t mode, logic msb);
    logic r;
    r = 1'b0;
    unique case (mode)
      MODE_PASS: r = 1'b0;
      MODE_NEG:  r = 1'b1;
      MODE_ABS:  r = msb;
      MODE_NABS: r = ~msb;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comple_serial_if.sv
// Operand-in / result-out handshake bundle
// for the digit-serial complementor.
interface comple_serial_if
  import comple_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  mode_t            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_zero
  );
endinterface

// File: rtl/comple_digit.sv
// One digit of conditional invert and ripple increment.
// Time-multiplexed across the operand by the top level.
module comple_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] digit,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, digit ^ {DIGIT{inv}}}
                     + {{DIGIT{1'b0}}, cin};
endmodule

// File: rtl/comple_serial.sv
// Digit-serial PASS/NEG/ABS/NABS unit with valid/ready
// handshakes; one DIGIT-wide slice per RUN cycle.
module comple_serial
  import comple_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  comple_serial_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam logic [WIDTH-1:0] MNEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] wnx;
  logic [WIDTH-1:0] dout;
  logic             inv;
  logic             carry;
  logic             ovf_q;
  logic             ovf;
  logic             zero;
  logic             inv_in;
  logic [DIGIT-1:0] sum;
  logic             cout;

  comple_digit #(.DIGIT(DIGIT)) u_digit (
    .digit (w[DIGIT-1:0]),
    .inv   (inv),
    .cin   (carry),
    .sum   (sum),
    .cout  (cout)
  );

  // Operand drains from the bottom while result fills from the top
  if (STEPS == 1) begin : g_one
    assign wnx = sum;
  end else begin : g_many
    assign wnx = {sum, w[WIDTH-1:DIGIT]};
  end

  assign inv_in = inv_sel(bus.in_mode, bus.in_data[WIDTH-1]);

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_data  = dout;
  assign bus.out_ovf   = ovf;
  assign bus.out_zero  = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      w     <= '0;
      dout  <= '0;
      inv   <= 1'b0;
      carry <= 1'b0;
      ovf_q <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            w     <= bus.in_data;
            inv   <= inv_in;
            carry <= inv_in;
            ovf_q <= inv_in && (bus.in_data == MNEG);
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          w     <= wnx;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            dout  <= wnx;
            zero  <= (wnx == '0);
            ovf   <= ovf_q;
            cnt   <= '0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comple_serial.sv
// Scoreboard bench: random and directed sign operations
// against a plain-arithmetic reference model.
module tb_comple_serial;
  import comple_pkg::*;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int STEPS = WIDTH / DIGIT;

  typedef struct {
    logic [15:0] d;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  bit   prev_v;
  bit   rnd_rdy;
  exp_t sb[$];

  comple_serial_if #(.WIDTH(WIDTH)) bus ();

  comple_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: signed arithmetic on the operand value
  function automatic exp_t model(input int m, input logic [15:0] d);
    exp_t e;
    int v;
    int r;
    v = int'($signed(d));
    case (m)
      0:       r = v;
      1:       r = -v;
      2:       r = (v < 0) ? -v : v;
      default: r = (v > 0) ? -v : v;
    endcase
    e.d    = r[15:0];
    e.zero = (e.d == 16'h0000);
    e.ovf  = (d == 16'h8000) && (m == 1 || m == 2);
    e.acc  = 0;
    return e;
  endfunction

  task automatic send(input int m, input logic [15:0] d);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = mode_t'(m[1:0]);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      chk("accept_timeout", 32'(n), 32'(0));
    end else begin
      @(posedge clk);
      #1;
      e = model(m, d);
      e.acc = cyc;
      sb.push_back(e);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    bus.in_mode  = mode_t'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'(0));
  endtask

  // Monitor: compares every DONE cycle, pops on handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 32'(bus.out_valid), 32'(0));
        end else begin
          e = sb[0];
          if (!prev_v)
            chk("latency", 32'(cyc - e.acc), 32'(STEPS));
          chk("out_data", 32'(bus.out_data), 32'(e.d));
          chk("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
          chk("out_zero", 32'(bus.out_zero), 32'(e.zero));
          chk("in_ready_done", 32'(bus.in_ready), 32'(0));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      prev_v = bus.out_valid;
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    int m;
    logic [15:0] d;
    errors = 0;
    checks = 0;
    rnd_rdy = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = MODE_PASS;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'(0));
    chk("rst_out_zero", 32'(bus.out_zero), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    send(2, 16'hFFFB);
    send(1, 16'h0000);
    send(1, 16'h0001);
    send(2, 16'h8000);
    send(1, 16'h8000);
    send(3, 16'h8000);
    send(0, 16'h1234);
    send(3, 16'h0007);
    send(3, 16'hFFF9);
    drain();

    // Backpressure: second operand must wait for the handshake
    bus.out_ready = 1'b0;
    send(1, 16'h00A5);
    fork
      send(2, 16'hFF80);
    join_none
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(bus.out_valid), 32'(1));
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait fork;
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      m = int'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       d = 16'h8000;
        1:       d = 16'h0000;
        2:       d = 16'hFFFF;
        3:       d = 16'h7FFF;
        default: d = 16'($urandom);
      endcase
      send(m, d);
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain();

    // Reset in the second RUN cycle discards the operation
    send(1, 16'h0003);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_in_ready", 32'(bus.in_ready), 32'(1));
    chk("mid_out_valid", 32'(bus.out_valid), 32'(0));
    chk("mid_out_data", 32'(bus.out_data), 32'(0));
    chk("mid_out_ovf", 32'(bus.out_ovf), 32'(0));
    chk("mid_out_zero", 32'(bus.out_zero), 32'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(2, 16'hFF00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
